// File: rtl/watch_time_if.sv
// rtl/watch_time_if.sv - button inputs and time/display outputs of the watch timekeeping controller
interface watch_time_if;
   logic       btn_mode;
   logic       btn_inc;
   logic       sec_tick;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [1:0] mode;
   logic       blink;

   // Controller side: consumes button pulses, drives time and display state
   modport slave (
      input  btn_mode, btn_inc,
      output sec_tick, hours, minutes, seconds, mode, blink
   );

   // User/display side: issues button pulses, observes time and display state
   modport master (
      output btn_mode, btn_inc,
      input  sec_tick, hours, minutes, seconds, mode, blink
   );
endinterface

// File: rtl/watch_time_ctrl.sv
// rtl/watch_time_ctrl.sv - 1 s prescaler, HH:MM:SS register and RUN/SET_HR/SET_MIN mode FSM with field blink
module watch_time_ctrl #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int BLINK_HZ = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   watch_time_if.slave  bus
);

   localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int PS_W       = $clog2(CLK_HZ);
   localparam int BL_W       = $clog2(BLINK_HALF);

   localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_HZ - 1);
   localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_HALF - 1);

   // Reject clock/blink ratios that would give a blink half-period under two cycles or a fractional one
   if ((CLK_HZ < 4 * BLINK_HZ) || ((CLK_HZ % (2 * BLINK_HZ)) != 0)) begin : g_param_check
      $error("watch_time_ctrl: CLK_HZ must be >= 4*BLINK_HZ and a multiple of 2*BLINK_HZ");
   end

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2
   } state_t;

   state_t          state;
   logic [PS_W-1:0] presc;
   logic [BL_W-1:0] bcnt;
   logic            tick_q;
   logic            blink_q;
   logic [4:0]      hours_q;
   logic [5:0]      minutes_q;
   logic [5:0]      seconds_q;

   // Mode FSM, prescaler, time-of-day and blink timing; a mode press always beats an increment press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_RUN;
         presc     <= '0;
         bcnt      <= '0;
         tick_q    <= 1'b0;
         blink_q   <= 1'b0;
         hours_q   <= 5'd0;
         minutes_q <= 6'd0;
         seconds_q <= 6'd0;
      end else begin
         tick_q <= 1'b0;
         if (bus.btn_mode) begin
            case (state)
               ST_RUN: begin
                  state   <= ST_SET_HR;
                  presc   <= '0;
                  bcnt    <= '0;
                  blink_q <= 1'b1;
               end
               ST_SET_HR: begin
                  state   <= ST_SET_MIN;
                  bcnt    <= '0;
                  blink_q <= 1'b1;
               end
               default: begin
                  // Leaving the editor restarts the second from zero so the next tick is a full period away
                  state     <= ST_RUN;
                  presc     <= '0;
                  bcnt      <= '0;
                  blink_q   <= 1'b0;
                  seconds_q <= 6'd0;
               end
            endcase
         end else begin
            case (state)
               ST_RUN: begin
                  if (presc == PS_MAX) begin
                     presc  <= '0;
                     tick_q <= 1'b1;
                     if (seconds_q == 6'd59) begin
                        seconds_q <= 6'd0;
                        if (minutes_q == 6'd59) begin
                           minutes_q <= 6'd0;
                           hours_q   <= (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                        end else begin
                           minutes_q <= minutes_q + 6'd1;
                        end
                     end else begin
                        seconds_q <= seconds_q + 6'd1;
                     end
                  end else begin
                     presc <= presc + PS_W'(1);
                  end
               end
               default: begin
                  // Set modes: time frozen except for the edited field, blink runs freely
                  if (bus.btn_inc) begin
                     if (state == ST_SET_HR) begin
                        hours_q <= (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                     end else begin
                        minutes_q <= (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                     end
                  end
                  if (bcnt == BL_MAX) begin
                     bcnt    <= '0;
                     blink_q <= ~blink_q;
                  end else begin
                     bcnt <= bcnt + BL_W'(1);
                  end
               end
            endcase
         end
      end
   end

   assign bus.sec_tick = tick_q;
   assign bus.hours    = hours_q;
   assign bus.minutes  = minutes_q;
   assign bus.seconds  = seconds_q;
   assign bus.mode     = state;
   assign bus.blink    = blink_q;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// tb/tb_watch_time_ctrl.sv - self-checking bench for watch_time_ctrl with CLK_HZ=10, BLINK_HZ=1
`timescale 1ns/1ps
module tb_watch_time_ctrl;
   localparam int CLK_HZ   = 10;
   localparam int BLINK_HZ = 1;

   typedef struct packed {
      logic       tick;
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic [1:0] mode;
      logic       blink;
   } snap_t;

   typedef struct {
      string name;
      logic  bm;
      logic  bi;
      int    reps;
      int    idle;
      snap_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   snap_t exp_q[$];
   vec_t  vq[$];

   always #5 clk = ~clk;

   watch_time_if bus();

   watch_time_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   function automatic snap_t mk(input int tick, input int h, input int m, input int s,
                                input int mode, input int blink);
      snap_t r;
      r.tick  = tick[0];
      r.h     = h[4:0];
      r.m     = m[5:0];
      r.s     = s[5:0];
      r.mode  = mode[1:0];
      r.blink = blink[0];
      return r;
   endfunction

   task automatic add(input string name, input logic bm, input logic bi, input int reps,
                      input int idle, input snap_t e);
      vec_t v;
      v.name = name; v.bm = bm; v.bi = bi; v.reps = reps; v.idle = idle; v.exp = e;
      vq.push_back(v);
   endtask

   task automatic check(input string name);
      snap_t a, e;
      a.tick = bus.sec_tick; a.h = bus.hours; a.m = bus.minutes; a.s = bus.seconds;
      a.mode = bus.mode; a.blink = bus.blink;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, got tick=%0b %0d:%0d:%0d mode=%0d blink=%0b",
                  name, a.tick, a.h, a.m, a.s, a.mode, a.blink);
         return;
      end
      e = exp_q.pop_front();
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got tick=%0b %0d:%0d:%0d mode=%0d blink=%0b, expected tick=%0b %0d:%0d:%0d mode=%0d blink=%0b",
                  name, a.tick, a.h, a.m, a.s, a.mode, a.blink,
                  e.tick, e.h, e.m, e.s, e.mode, e.blink);
      end
   endtask

   // One clock: drive buttons at the falling edge, leave outputs to settle to the next falling edge
   task automatic cyc(input logic bm, input logic bi);
      bus.btn_mode = bm;
      bus.btn_inc  = bi;
      @(posedge clk);
      @(negedge clk);
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         exp_q.push_back(vq[i].exp);
         for (int r = 0; r < vq[i].reps; r++) cyc(vq[i].bm, vq[i].bi);
         repeat (vq[i].idle) cyc(1'b0, 1'b0);
         check(vq[i].name);
      end
   endtask

   initial begin
      // 0..9: preload 23:59:59 through the editor and wrap at midnight
      add("t2_enter_hr",   1'b1, 1'b0, 1,  0,   mk(0, 0, 0, 3, 1, 1));
      add("t2_hr23",       1'b0, 1'b1, 23, 0,   mk(0, 23, 0, 3, 1, 1));
      add("t2_enter_min",  1'b1, 1'b0, 1,  0,   mk(0, 23, 0, 3, 2, 1));
      add("t2_min59",      1'b0, 1'b1, 59, 0,   mk(0, 23, 59, 3, 2, 0));
      add("t2_exit_run",   1'b1, 1'b0, 1,  0,   mk(0, 23, 59, 0, 0, 0));
      add("t2_sec59",      1'b0, 1'b0, 1,  589, mk(1, 23, 59, 59, 0, 0));
      add("t2_pre_wrap",   1'b0, 1'b0, 1,  8,   mk(0, 23, 59, 59, 0, 0));
      add("t2_wrap",       1'b0, 1'b0, 1,  0,   mk(1, 0, 0, 0, 0, 0));
      add("t2_post_wrap",  1'b0, 1'b0, 1,  0,   mk(0, 0, 0, 0, 0, 0));
      add("t2_sec5",       1'b0, 1'b0, 1,  48,  mk(1, 0, 0, 5, 0, 0));
      // 10..12: enter SET_HR at 00:00:05 and wrap hours with 25 increments
      add("t3_enter_hr",   1'b1, 1'b0, 1,  0,   mk(0, 0, 0, 5, 1, 1));
      add("t3_frozen",     1'b0, 1'b0, 1,  2,   mk(0, 0, 0, 5, 1, 1));
      add("t3_inc25",      1'b0, 1'b1, 25, 0,   mk(0, 1, 0, 5, 1, 0));
      // 13..15: simultaneous buttons, minute wrap without hour carry
      add("t5_both",       1'b1, 1'b1, 1,  0,   mk(0, 1, 0, 5, 2, 1));
      add("t4_min59",      1'b0, 1'b1, 59, 0,   mk(0, 1, 59, 5, 2, 0));
      add("t4_min_wrap",   1'b0, 1'b1, 1,  0,   mk(0, 1, 0, 5, 2, 1));
      // 16..19: increment ignored in RUN, then park in SET_MIN with blink low
      add("t5_inc_run",    1'b0, 1'b1, 3,  0,   mk(0, 1, 0, 1, 0, 0));
      add("t6_enter_hr",   1'b1, 1'b0, 1,  0,   mk(0, 1, 0, 1, 1, 1));
      add("t6_enter_min",  1'b1, 1'b0, 1,  0,   mk(0, 1, 0, 1, 2, 1));
      add("t6_blink_low",  1'b0, 1'b0, 1,  5,   mk(0, 1, 0, 1, 2, 0));

      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      check("reset_state");
      rst_n = 1'b1;

      // Free-running seconds: tick on every tenth clock
      for (int c = 1; c <= 30; c++) begin
         exp_q.push_back(mk((c % 10 == 0) ? 1 : 0, 0, 0, c / 10, 0, 0));
         cyc(1'b0, 1'b0);
         check("t1_run");
      end

      run_vecs(0, 12);

      // Blink period in SET_HR: offset k from entry edge, high during even groups of five
      for (int k = 29; k <= 48; k++) begin
         exp_q.push_back(mk(0, 1, 0, 5, 1, ((k / 5) % 2 == 0) ? 1 : 0));
         cyc(1'b0, 1'b0);
         check("t3_blink");
      end

      run_vecs(13, 15);

      // Exit SET_MIN: seconds cleared, next tick exactly ten clocks later
      exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
      cyc(1'b1, 1'b0);
      check("t4_exit");
      for (int c = 1; c <= 10; c++) begin
         exp_q.push_back(mk((c == 10) ? 1 : 0, 1, 0, (c == 10) ? 1 : 0, 0, 0));
         cyc(1'b0, 1'b0);
         check("t4_tick_gap");
      end

      run_vecs(16, 19);

      // Asynchronous reset between clock edges, then first tick a full period after release
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      check("t6_async_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         exp_q.push_back(mk((c == 10) ? 1 : 0, 0, 0, (c == 10) ? 1 : 0, 0, 0));
         cyc(1'b0, 1'b0);
         check("t6_release");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
